// File: rtl/noc_router_pkg.sv
// Shared router constants: default packet width, requester count, input port indices.
package noc_router_pkg;

   localparam int PACKET_WIDTH = 64;
   localparam int NUM_REQ      = 5;

   localparam int PORT_PE = 0;
   localparam int PORT_N  = 1;
   localparam int PORT_E  = 2;
   localparam int PORT_S  = 3;
   localparam int PORT_W  = 4;

   // Round-robin successor of idx among n requesters.
   function automatic int rr_next(input int idx, input int n);
      return (idx >= n - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/router_output_arbiter_rr_arbiter.sv
// Combinational round-robin search: first asserted request at or above ptr, wrapping.
module rr_arbiter
   import noc_router_pkg::*;
#(
   parameter int N  = 5,
   parameter int IW = 3
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  grant_o,
   output logic [IW-1:0] idx_o,
   output logic          any_o
);

   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      any_o   = 1'b0;
      for (int k = 0; k < N; k++) begin
         int j;
         j = int'(ptr_i) + k;
         if (j >= N) j = j - N;
         if (!any_o && req_i[j]) begin
            any_o      = 1'b1;
            grant_o[j] = 1'b1;
            idx_o      = IW'(j);
         end
      end
   end

endmodule

// File: rtl/router_output_arbiter.sv
// Router output stage: round-robin grant into a one-entry buffer, forwarded downstream
// with a one-cycle send strobe that never repeats back-to-back.
module router_output_arbiter #(
   parameter int PACKET_WIDTH = noc_router_pkg::PACKET_WIDTH,
   parameter int NUM_REQ      = noc_router_pkg::NUM_REQ
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_REQ-1:0]              req_valid,
   input  logic [NUM_REQ*PACKET_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]              req_grant,
   input  logic                            out_ri,
   output logic                            out_so,
   output logic [PACKET_WIDTH-1:0]         out_do,
   output logic                            busy,
   output logic [15:0]                     sent_count
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic                    full_q;
   logic                    out_so_q;
   logic [PACKET_WIDTH-1:0] buf_q;
   logic [PACKET_WIDTH-1:0] out_do_q;
   logic [IW-1:0]           ptr_q, ptr_d;
   logic [15:0]             cnt_q;

   logic [NUM_REQ-1:0]      arb_grant;
   logic [IW-1:0]           arb_idx;
   logic                    arb_any;
   logic                    send, accept;
   logic [PACKET_WIDTH-1:0] pkt_sel;

   rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
      .req_i   (req_valid),
      .ptr_i   (ptr_q),
      .grant_o (arb_grant),
      .idx_o   (arb_idx),
      .any_o   (arb_any)
   );

   // out_so_q blocks a second send while downstream's ready still reflects the old state.
   assign send   = full_q & out_ri & ~out_so_q;
   assign accept = reset & arb_any & (~full_q | send);

   assign req_grant = accept ? arb_grant : '0;
   assign ptr_d     = accept ? IW'(noc_router_pkg::rr_next(int'(arb_idx), NUM_REQ)) : ptr_q;

   always_comb begin
      pkt_sel = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (arb_grant[i]) pkt_sel = req_data[i*PACKET_WIDTH +: PACKET_WIDTH];
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         full_q   <= 1'b0;
         out_so_q <= 1'b0;
         buf_q    <= '0;
         out_do_q <= '0;
         ptr_q    <= '0;
         cnt_q    <= '0;
      end else begin
         out_so_q <= send;
         ptr_q    <= ptr_d;
         if (send) begin
            out_do_q <= buf_q;
            cnt_q    <= cnt_q + 16'd1;
         end
         if (accept) begin
            buf_q  <= pkt_sel;
            full_q <= 1'b1;
         end else if (send) begin
            full_q <= 1'b0;
         end
      end
   end

   assign out_so     = out_so_q;
   assign out_do     = out_do_q;
   assign busy       = full_q;
   assign sent_count = cnt_q;

endmodule

// File: doc/router_output_arbiter.md
ROUTER_OUTPUT_ARBITER -- requirements
Module: router_output_arbiter

Interface
REQ-001 SHALL have parameter PACKET_WIDTH, default 64, packet width in bits.
REQ-002 SHALL have parameter NUM_REQ, default 5, number of requesting input ports (PE, N, E, S, W).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, reset; one clock, reset is synchronous and active-low.
REQ-005 SHALL have port req_valid, input, NUM_REQ, bit i high means input port i holds a packet for this output.
REQ-006 SHALL have port req_data, input, NUM_REQ*PACKET_WIDTH, packet of requester i in slice [i*PACKET_WIDTH +: PACKET_WIDTH].
REQ-007 SHALL have port req_grant, output, NUM_REQ, one-hot, combinational; bit i high means req_data slice i is captured at this edge.
REQ-008 SHALL have port out_ri, input, 1, downstream ready (downstream input buffer empty).
REQ-009 SHALL have port out_so, output, 1, registered send strobe to downstream.
REQ-010 SHALL have port out_do, output, PACKET_WIDTH, registered packet data, valid while out_so high.
REQ-011 SHALL have port busy, output, 1, high while the output buffer holds a packet.
REQ-012 SHALL have port sent_count, output, 16, count of packets sent downstream.

Function
REQ-013 SHALL hold one packet in a one-entry output buffer; busy equals the buffer-full flag.
REQ-014 SHALL transfer (send) in a cycle where busy=1, out_ri=1 and out_so=0; at that edge out_so<=1, out_do<=buffer, full flag cleared unless refilled (REQ-016).
REQ-015 SHALL drive out_so low every cycle not following a send; out_so is never high two consecutive cycles (covers one-cycle out_ri lag); out_do holds its last value when out_so low.
REQ-016 SHALL accept a new packet when busy=0 or a send occurs the same cycle; on acceptance the buffer loads the granted slice and full flag is set.
REQ-017 SHALL assert exactly one req_grant bit when acceptance is possible and any req_valid bit is high, else all zero.
REQ-018 SHALL select the grant round-robin: first valid requester searching from pointer ptr upward, wrapping NUM_REQ-1 -> 0.
REQ-019 SHALL update ptr to (granted index + 1) mod NUM_REQ on each grant; ptr unchanged when no grant.
REQ-020 SHALL make req_grant a function of current-cycle req_valid, busy, out_ri, out_so, ptr only; requester drops req_valid for the granted packet on the following cycle.
REQ-021 SHALL increment sent_count by 1 at each send edge, wrapping 0xFFFF -> 0x0000.
REQ-022 SHALL, with busy=1 and out_ri=0, hold the buffer indefinitely, issue no grants and no sends.
REQ-023 SHALL sustain one packet per two cycles when out_ri stays high and requests are continuous.

Reset
REQ-024 SHALL, while reset=0 at a rising edge, clear full flag, out_so=0, out_do=0, ptr=0, sent_count=0; req_grant=0 during reset.
REQ-025 SHALL discard any buffered packet on reset mid-operation; no send in the cycle after reset deasserts.

Structure
REQ-026 SHALL take PACKET_WIDTH, NUM_REQ and port index constants (PE=0, N=1, E=2, S=3, W=4) from shared package noc_router_pkg.
REQ-027 SHALL implement the grant search in one combinational sub-module rr_arbiter (inputs req, ptr; output one-hot grant, index); pointer register stays in the parent.

Verification
REQ-028 Reset: reset=0 two cycles with all req_valid=5'b11111 -> req_grant=0, out_so=0, out_do=0, sent_count=0, busy=0.
REQ-029 Single request: req_valid=5'b00100, slice 2=64'hDEAD_BEEF, out_ri=1 -> req_grant=5'b00100 cycle 0, busy=1 cycle 1, out_so=1 with out_do=64'hDEAD_BEEF cycle 2, sent_count=1.
REQ-030 Round-robin: req_valid=5'b11111 held, out_ri=1 -> grant order 0,1,2,3,4,0, one grant per two cycles, out_so never high two consecutive cycles.
REQ-031 Backpressure: buffer full, out_ri=0 for 10 cycles -> no out_so, req_grant=0, busy=1; out_ri=1 -> send next edge, new grant same cycle.
REQ-032 Wrap: force 65535 sends -> sent_count=16'hFFFF; one more send -> 16'h0000.
REQ-033 Mid-operation reset: busy=1, ptr=3, assert reset one cycle -> busy=0, ptr=0, no send afterwards; next req_valid=5'b11111 grants requester 0.
